systolic_feeder: RTL and testbench

- Edge driver for the systolic MAC array. It buffers N A-row streams and N B-column streams of K signed 8-bit operands each.
- On start, it drives the streams into the array edge with diagonal skew (lane i delayed i cycles) and per-lane valid.
- It then waits for the array's result-valid handshake and reports done or timeout.
- It is the initiator/writer side of the PE operand interface (A_in/B_in/valid in, valid_out back).

---
 rtl/systolic_feeder.sv | 139 +++++++++++++
 tb/tb_systolic_feeder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Operand feeder for the edge of the systolic MAC array: buffers N A-row and
// N B-column streams, replays them with diagonal skew, then waits for the result.
module systolic_feeder #(
  parameter int N       = 2,
  parameter int K       = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 64,
  localparam int LW     = (N > 1) ? $clog2(N) : 1,
  localparam int AW     = (K > 1) ? $clog2(K) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [LW-1:0]   wr_lane,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  input  logic            res_valid,
  output logic [N*DW-1:0] a_out,
  output logic [N*DW-1:0] b_out,
  output logic [N-1:0]    a_valid,
  output logic [N-1:0]    b_valid,
  output logic            busy,
  output logic            done,
  output logic            timeout
);

  localparam int L  = K + N - 1;
  localparam int CW = $clog2(L + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST  = CW'(L - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [LW:0]   N_LIM   = (LW + 1)'(N);
  localparam logic [AW:0]   K_LIM   = (AW + 1)'(K);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   t;
  logic [TW-1:0]   wait_cnt;
  logic            res_seen;
  logic            expire;
  logic            wr_ok;
  logic [N*DW-1:0] a_nx, b_nx;
  logic [N-1:0]    v_nx;

  logic [DW-1:0] buf_a [N][K];
  logic [DW-1:0] buf_b [N][K];

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign wr_ok = wr_en && (state == S_IDLE) &&
                 ({1'b0, wr_lane} < N_LIM) && ({1'b0, wr_addr} < K_LIM);
  assign expire = (state == S_WAIT) && !(res_seen || res_valid) &&
                  (wait_cnt == TO_LAST);

  // Operand storage is deliberately not reset; contents persist across jobs.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel) buf_b[wr_lane][wr_addr] <= wr_data;
      else        buf_a[wr_lane][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_STREAM;
      S_STREAM: if (t == T_LAST) state_nx = S_WAIT;
      S_WAIT:   if (res_seen || res_valid || expire) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Lane i lags lane 0 by i cycles; A and B share the same skew.
  always_comb begin
    a_nx = '0;
    b_nx = '0;
    v_nx = '0;
    for (int i = 0; i < N; i++) begin
      int e;
      e = int'(t) - i;
      if (e >= 0 && e < K) begin
        a_nx[i*DW +: DW] = buf_a[i][e[AW-1:0]];
        b_nx[i*DW +: DW] = buf_b[i][e[AW-1:0]];
        v_nx[i]          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t        <= '0;
      wait_cnt <= '0;
      res_seen <= 1'b0;
      timeout  <= 1'b0;
      a_out    <= '0;
      b_out    <= '0;
      a_valid  <= '0;
      b_valid  <= '0;
    end else begin
      a_out   <= '0;
      b_out   <= '0;
      a_valid <= '0;
      b_valid <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            t        <= '0;
            wait_cnt <= '0;
            res_seen <= 1'b0;
            timeout  <= 1'b0;
          end
        end
        S_STREAM: begin
          a_out   <= a_nx;
          b_out   <= b_nx;
          a_valid <= v_nx;
          b_valid <= v_nx;
          t       <= t + CW'(1);
          if (res_valid) res_seen <= 1'b1;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + TW'(1);
          if (expire) timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: a scoreboard of skewed lane vectors is
// filled at each start and drained as the feeder streams.
module tb_systolic_feeder;

  localparam int N   = 2;
  localparam int K   = 4;
  localparam int DW  = 8;
  localparam int TMO = 64;
  localparam int L   = K + N - 1;

  logic            clk;
  logic            reset;
  logic            wr_en;
  logic            wr_sel;
  logic [0:0]      wr_lane;
  logic [1:0]      wr_addr;
  logic [DW-1:0]   wr_data;
  logic            start;
  logic            res_valid;
  logic [N*DW-1:0] a_out, b_out;
  logic [N-1:0]    a_valid, b_valid;
  logic            busy, done, timeout;

  typedef struct packed {
    logic [N-1:0]    av;
    logic [N-1:0]    bv;
    logic [N*DW-1:0] ao;
    logic [N*DW-1:0] bo;
  } vec_t;

  vec_t          sb_q[$];
  logic [DW-1:0] ma [N][K];
  logic [DW-1:0] mb [N][K];
  int            vectors;
  int            miscompares;

  systolic_feeder #(.N(N), .K(K), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_lane(wr_lane), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .res_valid(res_valid), .a_out(a_out), .b_out(b_out),
    .a_valid(a_valid), .b_valid(b_valid), .busy(busy), .done(done),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full write cycle; the model follows only writes the feeder should accept.
  task automatic apply_stimulus(input logic sel, input int lane, input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_lane = lane[0:0];
    wr_addr = addr[1:0];
    wr_data = data;
    if (sel) mb[lane][addr] = data;
    else     ma[lane][addr] = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_job();
    vec_t v;
    for (int t = 0; t < L; t++) begin
      v = '0;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < K) begin
          v.av[i] = 1'b1;
          v.bv[i] = 1'b1;
          v.ao[i*DW +: DW] = ma[i][t-i];
          v.bo[i*DW +: DW] = mb[i][t-i];
        end
      end
      sb_q.push_back(v);
    end
    sb_q.push_back('0);
  endtask

  // Called at a negedge. c counts negedges after start is sampled.
  task automatic run_job(input int res_at, input int exp_done, input logic exp_to, input int inject_at);
    vec_t v;
    int   c;
    bit   seen;
    start = 1'b1;
    push_job();
    @(negedge clk);
    c = 1;
    start = 1'b0;
    wr_en = 1'b0;
    check_output("busy_after_start", 64'(busy), 64'd1);
    check_output("timeout_cleared", 64'(timeout), 64'd0);
    res_valid = (c == res_at);
    seen = 1'b0;
    while (!seen && c < L + TMO + 20) begin
      @(negedge clk);
      c++;
      wr_en = 1'b0;
      start = 1'b0;
      if (sb_q.size() > 0) begin
        v = sb_q.pop_front();
        check_output("a_valid", 64'(a_valid), 64'(v.av));
        check_output("b_valid", 64'(b_valid), 64'(v.bv));
        check_output("a_out",   64'(a_out),   64'(v.ao));
        check_output("b_out",   64'(b_out),   64'(v.bo));
      end
      if (done) begin
        seen = 1'b1;
        check_output("done_cycle", 64'(c), 64'(exp_done));
        check_output("done_busy", 64'(busy), 64'd1);
        check_output("done_timeout", 64'(timeout), 64'(exp_to));
      end
      res_valid = (c == res_at);
      if (c == inject_at) begin
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_lane = 1'b0;
        wr_addr = 2'd0;
        wr_data = 8'hF9;
        start   = 1'b1;
      end
    end
    if (!seen) check_output("done_within_bound", 64'd0, 64'd1);
    res_valid = 1'b0;
    @(negedge clk);
    check_output("done_pulse_end", 64'(done), 64'd0);
    check_output("busy_end", 64'(busy), 64'd0);
    check_output("timeout_sticky", 64'(timeout), 64'(exp_to));
    sb_q.delete();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    wr_en = 1'b0; wr_sel = 1'b0; wr_lane = '0; wr_addr = '0; wr_data = '0;
    start = 1'b0; res_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_a_valid", 64'(a_valid), 64'd0);
    check_output("rst_a_out", 64'(a_out), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_timeout", 64'(timeout), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < K; k++) begin
      apply_stimulus(1'b0, 0, k, 8'(k + 1));
      apply_stimulus(1'b0, 1, k, 8'(k + 5));
      apply_stimulus(1'b1, 0, k, 8'(-(k + 1)));
      apply_stimulus(1'b1, 1, k, 8'(10 * (k + 1)));
    end

    $display("[TB] basic skew and handshake");
    run_job(L + 3, L + 4, 1'b0, 0);
    $display("[TB] early result during stream");
    run_job(3, L + 2, 1'b0, 0);
    $display("[TB] timeout");
    run_job(0, L + 1 + TMO, 1'b1, 0);
    repeat (3) @(negedge clk);
    check_output("timeout_held", 64'(timeout), 64'd1);
    $display("[TB] busy protection");
    run_job(L + 3, L + 4, 1'b0, 2);
    run_job(L + 3, L + 4, 1'b0, 0);

    $display("[TB] write and start in same cycle");
    wr_en = 1'b1; wr_sel = 1'b0; wr_lane = 1'b1; wr_addr = 2'd3; wr_data = 8'h80;
    ma[1][3] = 8'h80;
    run_job(L + 3, L + 4, 1'b0, 0);

    $display("[TB] async reset mid-stream");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_output("arst_a_valid", 64'(a_valid), 64'd0);
    check_output("arst_b_valid", 64'(b_valid), 64'd0);
    check_output("arst_a_out", 64'(a_out), 64'd0);
    check_output("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("arst_no_done", 64'(done), 64'd0);
    end
    run_job(L + 3, L + 4, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
